// File: rtl/metric_min_sel.sv
// metric_min_sel: tracks the smallest metric, and the position it arrived at,
// over a frame of NUM_CAND candidates. Frames are opened by start, and each
// complete frame ends with a registered one-cycle done pulse.
//
// Build option: define METRIC_SIGNED_EN to compare metrics as two's-complement
// values. best_metric then starts at 16'h7FFF instead of 16'hFFFF.
module metric_min_sel #(
    parameter int NUM_CAND = 16,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid,
    input  logic [15:0]      metric,
    output logic [15:0]      best_metric,
    output logic [IDX_W-1:0] best_idx,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_CAND);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

`ifdef METRIC_SIGNED_EN
    localparam logic [15:0] BEST_INIT = 16'h7FFF;
`else
    localparam logic [15:0] BEST_INIT = 16'hFFFF;
`endif

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             better;

    // Strict less-than against the running best, so a tie keeps the earlier index.
    always_comb begin
`ifdef METRIC_SIGNED_EN
        better = $signed(metric) < $signed(best_metric);
`else
        better = metric < best_metric;
`endif
        count_nxt = count + ONE;
    end

    // Frame control, running minimum and the registered status outputs.
    // NOTE: every register here uses <= so that all updates within one edge see
    // the values from before that edge (count and best_metric read each other).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            best_metric <= BEST_INIT;
            best_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // Open or restart a frame. A valid arriving in the same cycle is candidate 0.
                state    <= COLLECT;
                busy     <= 1'b1;
                best_idx <= '0;
                if (valid) begin
                    best_metric <= metric;
                    count       <= ONE;
                end else begin
                    best_metric <= BEST_INIT;
                    count       <= '0;
                end
            end else if (state == COLLECT && valid) begin
                // Candidate 0 always loads. Later candidates load only if strictly smaller.
                if (count == '0 || better) begin
                    best_metric <= metric;
                    best_idx    <= count[IDX_W-1:0];
                end
                count <= count_nxt;
                if (count_nxt == LAST_COUNT) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_metric_min_sel.sv
// tb_metric_min_sel: table-driven frames with a result scoreboard, plus
// hand-written sequences for restart, reset abort and stray valids.
module tb_metric_min_sel;

    localparam int NUM_CAND = 4;
    localparam int IDX_W    = 4;

`ifdef METRIC_SIGNED_EN
    localparam logic [15:0] RST_BEST = 16'h7FFF;
`else
    localparam logic [15:0] RST_BEST = 16'hFFFF;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic             valid;
    logic [15:0]      metric;
    logic [15:0]      best_metric;
    logic [IDX_W-1:0] best_idx;
    logic             busy;
    logic             done;

    metric_min_sel #(.NUM_CAND(NUM_CAND), .IDX_W(IDX_W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .valid(valid),
        .metric(metric),
        .best_metric(best_metric),
        .best_idx(best_idx),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             sv;          // start and first valid in the same cycle
        logic [3:0][15:0] m;           // m[0] arrives first
        logic [15:0]      exp_metric;
        logic [IDX_W-1:0] exp_idx;
    } vec_t;

    typedef struct packed {
        logic [15:0]      m;
        logic [IDX_W-1:0] i;
    } res_t;

    res_t sb_q[$];
    int   n_cmp     = 0;
    int   n_err     = 0;
    int   done_seen = 0;
    int   exp_done  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic sv, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d,
                                input logic [15:0] em, input logic [IDX_W-1:0] ei);
        vec_t v;
        v.sv         = sv;
        v.m          = {d, c, b, a};
        v.exp_metric = em;
        v.exp_idx    = ei;
        return v;
    endfunction

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic cycle(input logic st, input logic v, input logic [15:0] m);
        start  = st;
        valid  = v;
        metric = m;
        @(posedge clk);
        #1;
        start  = 1'b0;
        valid  = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] m, input logic [IDX_W-1:0] i);
        res_t r;
        r.m = m;
        r.i = i;
        sb_q.push_back(r);
        exp_done++;
    endtask

    // Scoreboard side: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                res_t r;
                r = sb_q.pop_front();
                check("sb_best_metric", 32'(best_metric), 32'(r.m));
                check("sb_best_idx", 32'(best_idx), 32'(r.i));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        push_exp(v.exp_metric, v.exp_idx);
        if (v.sv) begin
            cycle(1'b1, 1'b1, v.m[0]);
        end else begin
            cycle(1'b1, 1'b0, 16'h0);
            check("busy_after_start", 32'(busy), 32'(1));
            cycle(1'b0, 1'b1, v.m[0]);
        end
        check("cand0_metric", 32'(best_metric), 32'(v.m[0]));
        check("cand0_idx", 32'(best_idx), 32'(0));
        for (int k = 1; k < NUM_CAND; k++) begin
            check("no_early_done", 32'(done), 32'(0));
            cycle(1'b0, 1'b1, v.m[k]);
        end
        check("done_rise", 32'(done), 32'(1));
        check("busy_in_done", 32'(busy), 32'(0));
        cycle(1'b0, 1'b0, 16'h0);
        check("done_fall", 32'(done), 32'(0));
    endtask

    vec_t vecs[5];

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        valid  = 1'b0;
        metric = 16'h0;

        vecs[0] = mk(1'b0, 16'h0030, 16'h0010, 16'h0020, 16'h0010, 16'h0010, 4'd1);
        vecs[1] = mk(1'b1, 16'h0005, 16'h0007, 16'h0007, 16'h0007, 16'h0005, 4'd0);
`ifdef METRIC_SIGNED_EN
        vecs[2] = mk(1'b0, 16'h0002, 16'hFFFE, 16'h0001, 16'h0003, 16'hFFFE, 4'd1);
`else
        vecs[2] = mk(1'b0, 16'h0002, 16'hFFFE, 16'h0001, 16'h0003, 16'h0001, 4'd2);
`endif
        vecs[3] = mk(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'd0);
        vecs[4] = mk(1'b0, 16'h0040, 16'h0030, 16'h0020, 16'h0000, 16'h0000, 4'd3);

        // Reset state, both before and across a clock edge.
        #1 rst = 1'b1;
        #2;
        check("rst_best_metric", 32'(best_metric), 32'(RST_BEST));
        check("rst_best_idx", 32'(best_idx), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        @(posedge clk);
        #1;
        check("rst_hold_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Valids while idle change nothing.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'h1234);
        check("idle_best_metric", 32'(best_metric), 32'(16'h0000));
        check("idle_best_idx", 32'(best_idx), 32'(3));
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_done", 32'(done), 32'(0));

        // Restart mid-frame, then a stray valid in the DONE cycle.
        push_exp(16'h0006, 4'd3);
        cycle(1'b1, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h0001);
        cycle(1'b0, 1'b1, 16'h0002);
        cycle(1'b1, 1'b0, 16'h0);
        check("restart_busy", 32'(busy), 32'(1));
        cycle(1'b0, 1'b1, 16'h0009);
        cycle(1'b0, 1'b1, 16'h0008);
        cycle(1'b0, 1'b1, 16'h0007);
        check("restart_no_early_done", 32'(done), 32'(0));
        cycle(1'b0, 1'b1, 16'h0006);
        check("restart_done", 32'(done), 32'(1));
        cycle(1'b0, 1'b1, 16'h0000);
        check("done_valid_ignored_metric", 32'(best_metric), 32'(16'h0006));
        check("done_valid_ignored_idx", 32'(best_idx), 32'(3));
        check("done_to_idle_busy", 32'(busy), 32'(0));
        cycle(1'b0, 1'b1, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000);

        // Reset aborts a half-filled frame; later valids without start are ignored.
        cycle(1'b1, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h0050);
        cycle(1'b0, 1'b1, 16'h0060);
        #2 rst = 1'b1;
        #1;
        check("abort_best_metric", 32'(best_metric), 32'(RST_BEST));
        check("abort_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b0, 1'b1, 16'h0001);
        cycle(1'b0, 1'b1, 16'h0002);
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);
        check("post_abort_best_metric", 32'(best_metric), 32'(RST_BEST));
        check("post_abort_busy", 32'(busy), 32'(0));
        check("post_abort_done", 32'(done), 32'(0));

        check("done_pulse_count", 32'(done_seen), 32'(exp_done));
        check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/metric_min_sel.md
METRIC_MIN_SEL -- requirements
Module: metric_min_sel

Interface
REQ-001 Parameter NUM_CAND, default 16: number of candidate metrics per search frame, legal range 2..2**IDX_W.
REQ-002 Parameter IDX_W, default 4: width of the candidate index.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-high.
REQ-005 Port start  input  1: one-cycle pulse that opens a new search frame.
REQ-006 Port valid  input  1: one-cycle strobe marking a metric word; driven by the upstream trace stage's finish output.
REQ-007 Port metric  input  16: candidate metric, sampled when valid=1; driven by the upstream trace stage's out.
REQ-008 Port best_metric  output  16: smallest metric accepted so far in the current frame.
REQ-009 Port best_idx  output  IDX_W: arrival index (0-based) of best_metric within the frame.
REQ-010 Port busy  output  1: high while state is COLLECT.
REQ-011 Port done  output  1: registered one-cycle pulse marking a complete frame result.

Function
REQ-012 States:
- IDLE: no frame open.
- COLLECT: accepting metrics.
- DONE: result pulse cycle.
REQ-013 IDLE->COLLECT on start=1.
REQ-014 COLLECT->DONE on the valid that brings the accepted count to NUM_CAND.
REQ-015 DONE->IDLE unconditionally after one cycle, unless start=1 in that cycle, which moves directly to COLLECT.
REQ-016 start in COLLECT restarts the frame: count, best_metric and best_idx are cleared and the state stays COLLECT.
REQ-017 valid in IDLE or DONE, with start=0, is ignored and changes no register.
REQ-018 start and valid in the same cycle: the frame opens and metric is accepted as candidate 0; count becomes 1.
REQ-019 Candidate 0 of a frame always loads best_metric=metric and best_idx=0.
REQ-020 Candidate k>0 replaces the best only if metric < best_metric (strict), loading best_idx=k.
REQ-021 Ties keep the earlier index.
REQ-022 Comparison is unsigned unless the macro in REQ-029 is defined.
REQ-023 Count is IDX_W+1 bits wide, resets to 0 on every frame open, and never wraps within a frame.
REQ-024 best_metric and best_idx update in the cycle after the accepting valid (1-cycle latency).
REQ-025 done rises in the cycle after the NUM_CAND-th valid; best_metric and best_idx are final in that same cycle.
REQ-026 best_metric and best_idx hold their values after done until the next frame opens.

Reset
REQ-027 While rst=1, regardless of clk, the block SHALL hold:
- state=IDLE, count=0;
- best_metric=16'hFFFF, best_idx=0;
- busy=0, done=0.
REQ-028 rst asserted mid-frame aborts the frame; no done pulse follows, and a new start is required after rst is released.

Configuration
REQ-029 With macro METRIC_SIGNED_EN defined, metric and best_metric are compared as two's-complement signed values, and the reset value of best_metric is 16'h7FFF.
REQ-030 Without METRIC_SIGNED_EN, the comparison is unsigned and the reset value of best_metric is 16'hFFFF.

Verification
REQ-031 NUM_CAND=4, start, then valids with 0x0030, 0x0010, 0x0020, 0x0010 -> done one cycle after the 4th valid, best_metric=0x0010, best_idx=1 (tie keeps index 1).
REQ-032 start and valid together with 0x0005, then 3 valids with 0x0007 -> best_metric=0x0005, best_idx=0, done after the 4th accepted metric.
REQ-033 Restart: start, 2 valids (0x0001, 0x0002), start, 4 valids (9, 8, 7, 6) -> best_metric=0x0006, best_idx=3, exactly one done.
REQ-034 rst pulse after 2 of 4 valids, then 2 more valids with no start -> no done, best_metric=0xFFFF, busy=0.
REQ-035 Signed compare: METRIC_SIGNED_EN defined, metrics 0x0002, 0xFFFE, 0x0001, 0x0003 -> best_idx=1, best_metric=0xFFFE; without the macro -> best_idx=2, best_metric=0x0001.
REQ-036 valid strobes while IDLE -> outputs unchanged, busy=0, done=0.
